// File: rtl/l2_arb_pkg.sv
// Shared types and helpers for the N-port L1-to-L2 arbiter.
package l2_arb_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } arb_state_t;

   localparam int ARB_RR    = 1;
   localparam int ARB_FIXED = 0;

   // Index width that stays at least one bit wide, so a single-port build still has a grant_idx.
   function automatic int clog2_min1(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/l2_arbiter_nport_rr_picker.sv
// Combinational winner selection: round-robin from ptr when rr_en, otherwise lowest pending index.
module rr_picker
   import l2_arb_pkg::*;
#(
   parameter int N     = 2,
   parameter int IDX_W = clog2_min1(N)
) (
   input  logic [N-1:0]     pending,
   input  logic [IDX_W-1:0] ptr,
   input  logic             rr_en,
   output logic [IDX_W-1:0] winner_idx,
   output logic             any_pending
);

   // Scan upward from the base index with wrap; fixed priority is the same scan from port 0.
   always_comb begin
      int               base;
      int               cand;
      logic [IDX_W-1:0] cand_idx;
      logic             found;
      base       = rr_en ? int'(ptr) : 0;
      cand       = 0;
      cand_idx   = '0;
      found      = 1'b0;
      winner_idx = '0;
      for (int k = 0; k < N; k++) begin
         cand = base + k;
         if (cand >= N) begin
            cand = cand - N;
         end
         cand_idx = IDX_W'(cand);
         if (!found && pending[cand_idx]) begin
            found      = 1'b1;
            winner_idx = cand_idx;
         end
      end
   end

   assign any_pending = |pending;

endmodule

// File: rtl/l2_arbiter_nport.sv
// N-requester arbiter in front of the single-ported L2: picks one L1 port, latches its request,
// and holds the L2 inputs stable until the L2 completes.
module l2_arbiter_nport
   import l2_arb_pkg::*;
#(
   parameter int  N_PORTS = 2,
   parameter int  ADDR_W  = 32,
   parameter int  LINE_W  = 256,
   parameter int  RR_MODE = 1,
   localparam int IDX_W   = clog2_min1(N_PORTS)
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [N_PORTS-1:0]          req_read,
   input  logic [N_PORTS-1:0]          req_write,
   input  logic [N_PORTS*ADDR_W-1:0]   req_address,
   input  logic [N_PORTS*LINE_W-1:0]   req_wdata,
   output logic [N_PORTS-1:0]          req_resp,
   output logic [LINE_W-1:0]           req_rdata,
   output logic                        l2_read,
   output logic                        l2_write,
   output logic [ADDR_W-1:0]           l2_address,
   output logic [LINE_W-1:0]           l2_wdata,
   input  logic                        l2_resp,
   input  logic [LINE_W-1:0]           l2_rdata,
   output logic                        grant_valid,
   output logic [IDX_W-1:0]            grant_idx
);

   arb_state_t        state;
   arb_state_t        state_next;
   logic [IDX_W-1:0]  rr_ptr;
   logic [IDX_W-1:0]  winner_idx;
   logic              any_pending;
   logic [N_PORTS-1:0] pending;
   logic              capture;
   logic              complete;
   logic [ADDR_W-1:0] sel_addr;
   logic [LINE_W-1:0] sel_wdata;
   logic              sel_write;
   logic [ADDR_W-1:0] cap_addr;
   logic [LINE_W-1:0] cap_wdata;
   logic              cap_write;

   assign pending = req_read | req_write;

   rr_picker #(
      .N     (N_PORTS),
      .IDX_W (IDX_W)
   ) u_picker (
      .pending     (pending),
      .ptr         (rr_ptr),
      .rr_en       (RR_MODE == ARB_RR),
      .winner_idx  (winner_idx),
      .any_pending (any_pending)
   );

   // Route the winning port's request fields; a simultaneous read+write is served as a write.
   always_comb begin
      sel_addr  = '0;
      sel_wdata = '0;
      sel_write = 1'b0;
      for (int i = 0; i < N_PORTS; i++) begin
         if (winner_idx == IDX_W'(i)) begin
            sel_addr  = req_address[i*ADDR_W +: ADDR_W];
            sel_wdata = req_wdata[i*LINE_W +: LINE_W];
            sel_write = req_write[i];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // L2 strobes come only from captured state; completion is passed straight back to the owner.
   always_comb begin
      state_next = state;
      capture    = 1'b0;
      complete   = 1'b0;
      l2_read    = 1'b0;
      l2_write   = 1'b0;
      req_resp   = '0;
      req_rdata  = '0;
      case (state)
         IDLE: begin
            if (any_pending) begin
               capture    = 1'b1;
               state_next = BUSY;
            end
         end
         BUSY: begin
            l2_read  = !cap_write;
            l2_write = cap_write;
            if (l2_resp) begin
               complete            = 1'b1;
               req_resp[grant_idx] = 1'b1;
               req_rdata           = l2_rdata;
               state_next          = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Capture registers and the round-robin pointer; the pointer moves past the port just served.
   always_ff @(posedge clk) begin
      if (rst) begin
         cap_addr  <= '0;
         cap_wdata <= '0;
         cap_write <= 1'b0;
         grant_idx <= '0;
         rr_ptr    <= '0;
      end else begin
         if (capture) begin
            cap_addr  <= sel_addr;
            cap_wdata <= sel_wdata;
            cap_write <= sel_write;
            grant_idx <= winner_idx;
         end
         if (complete && (RR_MODE == ARB_RR)) begin
            rr_ptr <= (grant_idx == IDX_W'(N_PORTS - 1)) ? '0 : grant_idx + IDX_W'(1);
         end
      end
   end

   assign grant_valid = (state == BUSY);
   assign l2_address  = cap_addr;
   assign l2_wdata    = cap_wdata;

endmodule

// File: tb/tb_l2_arbiter_nport.sv
// Scoreboard bench: a 4-port round-robin arbiter and a 2-port fixed-priority arbiter driven by
// directed transactions; monitors compare every req_resp cycle against queued expectations.
module tb_l2_arbiter_nport;

   typedef struct {
      logic [3:0]   resp;
      logic [31:0]  addr;
      logic [255:0] wdata;
      logic         wr;
      logic [255:0] rdata;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic [3:0]    rr_req_read, rr_req_write, rr_req_resp;
   logic [127:0]  rr_req_address;
   logic [1023:0] rr_req_wdata;
   logic [255:0]  rr_req_rdata, rr_l2_wdata, rr_l2_rdata;
   logic          rr_l2_read, rr_l2_write, rr_l2_resp, rr_grant_valid;
   logic [31:0]   rr_l2_address;
   logic [1:0]    rr_grant_idx;

   logic [1:0]    fx_req_read, fx_req_write, fx_req_resp;
   logic [63:0]   fx_req_address;
   logic [511:0]  fx_req_wdata;
   logic [255:0]  fx_req_rdata, fx_l2_wdata, fx_l2_rdata;
   logic          fx_l2_read, fx_l2_write, fx_l2_resp, fx_grant_valid;
   logic [31:0]   fx_l2_address;
   logic [0:0]    fx_grant_idx;

   exp_t rr_q[$];
   exp_t fx_q[$];
   int   compared   = 0;
   int   mismatched = 0;

   logic [255:0] wd [4];

   l2_arbiter_nport #(.N_PORTS(4), .ADDR_W(32), .LINE_W(256), .RR_MODE(1)) dut_rr (
      .clk(clk), .rst(rst),
      .req_read(rr_req_read), .req_write(rr_req_write),
      .req_address(rr_req_address), .req_wdata(rr_req_wdata),
      .req_resp(rr_req_resp), .req_rdata(rr_req_rdata),
      .l2_read(rr_l2_read), .l2_write(rr_l2_write),
      .l2_address(rr_l2_address), .l2_wdata(rr_l2_wdata),
      .l2_resp(rr_l2_resp), .l2_rdata(rr_l2_rdata),
      .grant_valid(rr_grant_valid), .grant_idx(rr_grant_idx)
   );

   l2_arbiter_nport #(.N_PORTS(2), .ADDR_W(32), .LINE_W(256), .RR_MODE(0)) dut_fx (
      .clk(clk), .rst(rst),
      .req_read(fx_req_read), .req_write(fx_req_write),
      .req_address(fx_req_address), .req_wdata(fx_req_wdata),
      .req_resp(fx_req_resp), .req_rdata(fx_req_rdata),
      .l2_read(fx_l2_read), .l2_write(fx_l2_write),
      .l2_address(fx_l2_address), .l2_wdata(fx_l2_wdata),
      .l2_resp(fx_l2_resp), .l2_rdata(fx_l2_rdata),
      .grant_valid(fx_grant_valid), .grant_idx(fx_grant_idx)
   );

   task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic exp_t mkExp(input logic [3:0] resp, input logic [31:0] addr,
                                  input logic [255:0] wdata, input logic wr,
                                  input logic [255:0] rdata);
      exp_t e;
      e.resp  = resp;
      e.addr  = addr;
      e.wdata = wdata;
      e.wr    = wr;
      e.rdata = rdata;
      return e;
   endfunction

   task automatic applyStimulus(input int p, input logic rd, input logic wr,
                                input logic [31:0] addr, input logic [255:0] wdata);
      rr_req_read[p]               = rd;
      rr_req_write[p]              = wr;
      rr_req_address[p*32 +: 32]   = addr;
      rr_req_wdata[p*256 +: 256]   = wdata;
   endtask

   task automatic waitBusy(input bit fx, input string name);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!(fx ? fx_grant_valid : rr_grant_valid) && n < 20);
      if (!(fx ? fx_grant_valid : rr_grant_valid))
         checkOutput({name, " grant timeout"}, 256'd0, 256'd1);
   endtask

   task automatic serveL2(input bit fx, input int lat, input logic [255:0] rdata);
      repeat (lat) @(posedge clk);
      #1;
      if (fx) begin
         fx_l2_resp  = 1'b1;
         fx_l2_rdata = rdata;
      end else begin
         rr_l2_resp  = 1'b1;
         rr_l2_rdata = rdata;
      end
      @(posedge clk);
      #1;
      fx_l2_resp = 1'b0;
      rr_l2_resp = 1'b0;
   endtask

   task automatic doTxn(input int port, input logic [31:0] addr, input logic [255:0] wdata,
                        input logic wr, input logic [255:0] rdata, input int lat);
      waitBusy(0, "rr");
      checkOutput("rr grant_idx", 256'(rr_grant_idx), 256'(port));
      rr_q.push_back(mkExp(4'(1 << port), addr, wdata, wr, rdata));
      serveL2(0, lat, rdata);
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (rr_req_resp != 4'b0) begin
         if (rr_q.size() == 0) begin
            checkOutput("rr unexpected req_resp", 256'(rr_req_resp), 256'd0);
         end else begin
            e = rr_q.pop_front();
            checkOutput("rr req_resp",   256'(rr_req_resp),   256'(e.resp));
            checkOutput("rr l2_address", 256'(rr_l2_address), 256'(e.addr));
            checkOutput("rr l2_write",   256'(rr_l2_write),   256'(e.wr));
            checkOutput("rr l2_read",    256'(rr_l2_read),    256'(!e.wr));
            checkOutput("rr l2_wdata",   rr_l2_wdata,         e.wdata);
            checkOutput("rr req_rdata",  rr_req_rdata,        e.rdata);
         end
      end
   end

   always @(negedge clk) begin
      exp_t e;
      if (fx_req_resp != 2'b0) begin
         if (fx_q.size() == 0) begin
            checkOutput("fx unexpected req_resp", 256'(fx_req_resp), 256'd0);
         end else begin
            e = fx_q.pop_front();
            checkOutput("fx req_resp",   256'(fx_req_resp),   256'(e.resp));
            checkOutput("fx l2_address", 256'(fx_l2_address), 256'(e.addr));
            checkOutput("fx l2_read",    256'(fx_l2_read),    256'(!e.wr));
            checkOutput("fx req_rdata",  fx_req_rdata,        e.rdata);
         end
      end
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      for (int i = 0; i < 4; i++) wd[i] = {8{32'hD000_0000 | 32'(i)}};
      rst = 1'b1;
      rr_req_read = '0; rr_req_write = '0; rr_req_address = '0; rr_req_wdata = '0;
      rr_l2_resp = 1'b0; rr_l2_rdata = '0;
      fx_req_read = '0; fx_req_write = '0; fx_req_address = '0; fx_req_wdata = '0;
      fx_l2_resp = 1'b0; fx_l2_rdata = '0;

      @(posedge clk);
      @(negedge clk);
      checkOutput("reset l2_read",     256'(rr_l2_read),     256'd0);
      checkOutput("reset l2_write",    256'(rr_l2_write),    256'd0);
      checkOutput("reset req_resp",    256'(rr_req_resp),    256'd0);
      checkOutput("reset grant_valid", 256'(rr_grant_valid), 256'd0);
      checkOutput("reset grant_idx",   256'(rr_grant_idx),   256'd0);
      checkOutput("reset l2_address",  256'(rr_l2_address),  256'd0);
      checkOutput("reset l2_wdata",    rr_l2_wdata,          256'd0);
      checkOutput("reset fx grant_valid", 256'(fx_grant_valid), 256'd0);
      @(posedge clk);
      #1 rst = 1'b0;

      // Round-robin alternation between two held requests.
      applyStimulus(0, 1'b1, 1'b0, 32'h1000, wd[0]);
      applyStimulus(1, 1'b0, 1'b1, 32'h2000, wd[1]);
      for (int k = 0; k < 4; k++) begin
         doTxn(k % 2, (k % 2) ? 32'h2000 : 32'h1000, wd[k % 2], 1'((k % 2) != 0),
               256'h1111_0000 + 256'(k), 3);
      end
      applyStimulus(0, 1'b0, 1'b0, 32'h1000, wd[0]);
      applyStimulus(1, 1'b0, 1'b0, 32'h2000, wd[1]);

      // Captured request must not follow the requester once granted.
      @(posedge clk);
      #1 applyStimulus(0, 1'b1, 1'b0, 32'h40, wd[0]);
      waitBusy(0, "capture");
      checkOutput("capture grant_idx", 256'(rr_grant_idx), 256'd0);
      @(posedge clk);
      #1 rr_req_address[31:0] = 32'h80;
      @(negedge clk);
      checkOutput("capture l2_address held", 256'(rr_l2_address), 256'h40);
      rr_q.push_back(mkExp(4'b0001, 32'h40, wd[0], 1'b0, {32{8'hA5}}));
      serveL2(0, 1, {32{8'hA5}});
      applyStimulus(0, 1'b0, 1'b0, 32'h40, wd[0]);

      // Read and write together on one port is a write.
      @(posedge clk);
      #1 applyStimulus(2, 1'b1, 1'b1, 32'h3000, wd[2]);
      doTxn(2, 32'h3000, wd[2], 1'b1, 256'h5555, 1);
      applyStimulus(2, 1'b0, 1'b0, 32'h3000, wd[2]);

      // Pointer now at 3: port 3 wins, then port 1 after a one-cycle idle gap.
      @(posedge clk);
      #1;
      applyStimulus(1, 1'b1, 1'b0, 32'h5000, wd[1]);
      applyStimulus(3, 1'b0, 1'b1, 32'h6000, wd[3]);
      @(negedge clk);
      checkOutput("timing l2_write same cycle", 256'(rr_l2_write), 256'd0);
      @(negedge clk);
      checkOutput("timing l2_write next cycle", 256'(rr_l2_write), 256'd1);
      checkOutput("timing grant_idx port3",    256'(rr_grant_idx), 256'd3);
      rr_q.push_back(mkExp(4'b1000, 32'h6000, wd[3], 1'b1, 256'h6666));
      serveL2(0, 2, 256'h6666);
      applyStimulus(3, 1'b0, 1'b0, 32'h6000, wd[3]);
      @(negedge clk);
      checkOutput("gap grant_valid", 256'(rr_grant_valid), 256'd0);
      checkOutput("gap l2_read",     256'(rr_l2_read),     256'd0);
      @(negedge clk);
      checkOutput("after gap grant_valid", 256'(rr_grant_valid), 256'd1);
      checkOutput("after gap grant_idx",   256'(rr_grant_idx),   256'd1);
      checkOutput("after gap l2_read",     256'(rr_l2_read),     256'd1);
      rr_q.push_back(mkExp(4'b0010, 32'h5000, wd[1], 1'b0, 256'h7777));
      serveL2(0, 1, 256'h7777);
      applyStimulus(1, 1'b0, 1'b0, 32'h5000, wd[1]);

      // Reset in BUSY abandons the transfer; a late l2_resp is ignored.
      @(posedge clk);
      #1;
      applyStimulus(0, 1'b1, 1'b0, 32'h7000, wd[0]);
      applyStimulus(3, 1'b1, 1'b0, 32'h7100, wd[3]);
      waitBusy(0, "pre-reset");
      checkOutput("pre-reset grant_idx", 256'(rr_grant_idx), 256'd3);
      @(posedge clk);
      #1;
      rst = 1'b1;
      applyStimulus(0, 1'b0, 1'b0, 32'h7000, wd[0]);
      applyStimulus(3, 1'b0, 1'b0, 32'h7100, wd[3]);
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      checkOutput("post-reset grant_valid", 256'(rr_grant_valid), 256'd0);
      checkOutput("post-reset l2_read",     256'(rr_l2_read),     256'd0);
      checkOutput("post-reset l2_address",  256'(rr_l2_address),  256'd0);
      checkOutput("post-reset grant_idx",   256'(rr_grant_idx),   256'd0);
      @(posedge clk);
      #1;
      rr_l2_resp  = 1'b1;
      rr_l2_rdata = 256'hDEAD;
      @(negedge clk);
      checkOutput("late l2_resp req_resp",  256'(rr_req_resp),  256'd0);
      checkOutput("late l2_resp req_rdata", rr_req_rdata,       256'd0);
      @(posedge clk);
      #1;
      rr_l2_resp = 1'b0;
      applyStimulus(0, 1'b1, 1'b0, 32'h7000, wd[0]);
      applyStimulus(3, 1'b1, 1'b0, 32'h7100, wd[3]);
      doTxn(0, 32'h7000, wd[0], 1'b0, 256'h8888, 1);
      applyStimulus(0, 1'b0, 1'b0, 32'h7000, wd[0]);
      applyStimulus(3, 1'b0, 1'b0, 32'h7100, wd[3]);

      // Fixed priority: port 0 starves port 1.
      @(posedge clk);
      #1;
      fx_req_read             = 2'b11;
      fx_req_address          = {32'h200, 32'h100};
      fx_req_wdata[255:0]     = wd[0];
      fx_req_wdata[511:256]   = wd[1];
      for (int k = 0; k < 5; k++) begin
         waitBusy(1, "fx");
         checkOutput("fx grant_idx", 256'(fx_grant_idx), 256'd0);
         fx_q.push_back(mkExp(4'b0001, 32'h100, wd[0], 1'b0, 256'h9900 + 256'(k)));
         serveL2(1, 1, 256'h9900 + 256'(k));
      end
      fx_req_read = 2'b00;

      repeat (3) @(negedge clk);
      checkOutput("rr scoreboard drained", 256'(rr_q.size()), 256'd0);
      checkOutput("fx scoreboard drained", 256'(fx_q.size()), 256'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/l2_arbiter_nport.md
Name: l2_arbiter_nport

Overview:
- Parametrised N-requester arbiter between the L1 cache cores (icache, dcache, future prefetch/victim ports) and the single-ported L2 `cache_core`.
- Generalises the fixed two-port i/d arbiter with:
  - N ports
  - selectable round-robin or fixed priority
  - a registered request capture, so L2 inputs are stable for the whole transaction
  - an explicit synchronous reset
- Sits between the L1 `downstream_*` ports and the L2 `upstream_*` ports.

Parameters:
N_PORTS, 2, number of requesting caches (1..8)
ADDR_W, 32, address width
LINE_W, 256, cache line width
RR_MODE, 1, 1 = round-robin priority; 0 = fixed priority (port 0 highest)

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous active-high reset
req_read  in  N_PORTS  per-port line read request, held until its resp
req_write  in  N_PORTS  per-port line write(-back) request, held until its resp
req_address  in  N_PORTS*ADDR_W  per-port address, port i at [i*ADDR_W +: ADDR_W]
req_wdata  in  N_PORTS*LINE_W  per-port write line, port i at [i*LINE_W +: LINE_W]
req_resp  out  N_PORTS  one-hot completion pulse to the granted port
req_rdata  out  LINE_W  shared read line; valid only with req_resp
l2_read  out  1  read request to L2
l2_write  out  1  write request to L2
l2_address  out  ADDR_W  L2 address
l2_wdata  out  LINE_W  L2 write line
l2_resp  in  1  L2 completion
l2_rdata  in  LINE_W  L2 read line
grant_valid  out  1  transaction in flight (debug/perf)
grant_idx  out  $clog2(N_PORTS) (min 1)  current or last granted port

Behaviour:
- Reset (rst high at posedge):
  - state=IDLE; rr_ptr=0; grant_idx=0.
  - All outputs 0: l2_read, l2_write, req_resp, grant_valid; l2_address, l2_wdata, req_rdata also 0.
  - Reset wins over every other event.
  - Reset mid-BUSY abandons the transaction. An l2_resp arriving later in IDLE is ignored and produces no req_resp.
- Port i is "pending" when req_read[i] | req_write[i]. If both are high, the request is treated as a write.
- State IDLE:
  - Outputs l2_read=l2_write=0.
  - If any port is pending, pick a winner:
    - RR_MODE=1: the first pending port at or after rr_ptr, scanning upward with wrap N_PORTS-1 -> 0.
    - RR_MODE=0: the lowest-index pending port.
  - At the edge, capture the winner's address, wdata and op into internal registers; grant_idx=winner; go to BUSY.
- State BUSY:
  - l2_read or l2_write is driven from the captured op; l2_address and l2_wdata come from the capture registers.
  - Requester changes after capture are ignored.
  - grant_valid=1.
  - Each cycle with l2_resp=1:
    - req_resp[grant_idx]=1 combinationally in the same cycle; req_rdata=l2_rdata passthrough.
    - Next state IDLE.
    - rr_ptr = grant_idx+1, wrapping to 0 after N_PORTS-1. rr_ptr is unchanged in fixed mode.
  - With l2_resp=0, stay in BUSY; there is no timeout.
- Latency:
  - Request to l2_read/l2_write: 1 cycle.
  - l2_resp to req_resp: 0 cycles.
  - After a resp there is at least one IDLE cycle before the next L2 request, so back-to-back throughput is one transaction per (L2 latency + 1) cycles.
  - A port whose request is still high in the IDLE cycle after its resp is treated as a new request.
- A request dropped while it is not granted is simply not served; no state is kept for it.
- Fairness: in RR mode, with all ports continuously pending, the grants cycle 0,1,...,N-1,0.
- Single-port build (N_PORTS=1): the arbiter degenerates to a capture register plus FSM; grant_idx is always 0.
- No combinational path from req_* to l2_* outputs. l2_resp to req_resp/req_rdata is combinational.

Decomposition:
- Package l2_arb_pkg:
  - state enum arb_state_t {IDLE, BUSY}
  - localparam constants ARB_RR=1, ARB_FIXED=0
  - function clog2_min1
- One combinational sub-module, rr_picker #(N), with inputs pending[N], ptr and rr_en, and outputs winner_idx and any_pending.
- The top level holds the FSM, capture registers and rr_ptr.

Test Plan:
1. rr_ptr wrap in RR mode:
   - Stimulus: N=2, RR; port0 read 0x1000 and port1 write 0x2000 both held; L2 resp after 3 cycles each.
   - Required: grant sequence 0,1,0,1; l2_address 0x1000 then 0x2000; req_resp 2'b01 then 2'b10.
2. Fixed-priority starvation:
   - Stimulus: RR_MODE=0, both ports continuously pending.
   - Required: port0 wins every transaction; port1 gets no req_resp over 5 transactions.
3. Capture stability:
   - Stimulus: port0 read 0x40 is granted; the requester changes req_address to 0x80 in BUSY.
   - Required: l2_address stays 0x40 until l2_resp; req_rdata=l2_rdata (0xA5.. pattern) in the resp cycle.
4. Reset mid-transaction:
   - Stimulus: rst is pulsed in BUSY; l2_resp arrives 2 cycles later.
   - Required: all outputs 0 the cycle after rst; no req_resp; next grant starts from port 0.
5. Simultaneous read and write on one port:
   - Stimulus: N=4, RR; port2 asserts read and write together.
   - Required: l2_write=1, l2_read=0.
6. Idle-gap timing:
   - Stimulus: rr_ptr=3 with ports 1 and 3 pending.
   - Required: port3 is granted and l2_write rises exactly 1 cycle after request; after resp, rr_ptr=0 and port1 is granted next after a 1-cycle IDLE gap.
